id_wide: RTL and testbench

ID_WIDE -- requirements
Module: id_wide

---
 rtl/id_pkg.sv | 48 ++++
 rtl/id_lane_dec.sv | 72 +++++++
 rtl/id_wide.sv | 110 +++++++++++
 tb/tb_id_wide.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode constants for the wide instruction-decode stage: opcodes,
// control-vector bit positions, ALUOp encodings and the per-lane record.
package id_pkg;

  localparam int CTRL_W = 11;

  localparam int CTRL_REGDST   = 0;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_BRANCH   = 6;
  localparam int CTRL_ALUOP_LO = 7;
  localparam int CTRL_ALUOP_HI = 8;
  localparam int CTRL_JUMP     = 9;
  localparam int CTRL_ILLEGAL  = 10;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_IMM    = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        dest;
    logic [31:0]       imm;
    logic [CTRL_W-1:0] ctrl;
  } lane_dec_t;

endpackage

// File: rtl/id_lane_dec.sv
// Combinational decoder for one instruction word: control vector, register
// numbers and extended immediate.
module id_lane_dec
  import id_pkg::*;
(
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        dest,
  output logic [31:0]       imm
);

  logic [5:0] opcode;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];

  always_comb begin
    ctrl = '0;
    casez (opcode)
      OP_RTYPE: begin
        ctrl[CTRL_REGDST]                 = 1'b1;
        ctrl[CTRL_REGWRITE]               = 1'b1;
        ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_RTYPE;
      end
      OP_LW: begin
        ctrl[CTRL_ALUSRC]                 = 1'b1;
        ctrl[CTRL_MEMTOREG]               = 1'b1;
        ctrl[CTRL_REGWRITE]               = 1'b1;
        ctrl[CTRL_MEMREAD]                = 1'b1;
        ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_MEM;
      end
      OP_SW: begin
        ctrl[CTRL_ALUSRC]   = 1'b1;
        ctrl[CTRL_MEMWRITE] = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl[CTRL_BRANCH]                 = 1'b1;
        ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_BRANCH;
      end
      OP_J: ctrl[CTRL_JUMP] = 1'b1;
      OP_JAL: begin
        ctrl[CTRL_JUMP]     = 1'b1;
        ctrl[CTRL_REGWRITE] = 1'b1;
      end
      6'b001???: begin
        ctrl[CTRL_ALUSRC]                 = 1'b1;
        ctrl[CTRL_REGWRITE]               = 1'b1;
        ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_IMM;
      end
      default: ctrl[CTRL_ILLEGAL] = 1'b1;
    endcase
  end

  always_comb begin
    if (opcode == OP_JAL)          dest = REG_RA;
    else if (ctrl[CTRL_REGDST])    dest = instr[15:11];
    else                           dest = instr[20:16];
  end

  // Logical immediates zero-extend; lui places the field in the upper half.
  always_comb begin
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: imm = {16'h0000, instr[15:0]};
      OP_LUI:                   imm = {instr[15:0], 16'h0000};
      default:                  imm = {{16{instr[15]}}, instr[15:0]};
    endcase
  end

endmodule

// File: rtl/id_wide.sv
// Multi-lane decode stage: decodes a fetch bundle per cycle into a small
// in-order output buffer with valid/ready on both sides.
module id_wide
  import id_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int BUF_DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     FLUSH,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [LANES-1:0]         IN_LANE_V,
  input  logic [32*LANES-1:0]      IN_INSTR,
  input  logic [32*LANES-1:0]      IN_PC,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [LANES-1:0]         OUT_LANE_V,
  output logic [32*LANES-1:0]      OUT_INSTR,
  output logic [32*LANES-1:0]      OUT_PC,
  output logic [5*LANES-1:0]       OUT_RS,
  output logic [5*LANES-1:0]       OUT_RT,
  output logic [5*LANES-1:0]       OUT_DEST,
  output logic [32*LANES-1:0]      OUT_IMM,
  output logic [CTRL_W*LANES-1:0]  OUT_CTRL
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;

  lane_dec_t        dec_lane [LANES];
  lane_dec_t        buf_data [BUF_DEPTH][LANES];
  logic [LANES-1:0] buf_lv   [BUF_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on the registered count, never on OUT_READY.
  assign IN_READY  = (count < DEPTH_C);
  assign OUT_VALID = (count != '0);
  assign push      = IN_VALID & IN_READY & ~FLUSH;
  assign pop       = OUT_VALID & OUT_READY & ~FLUSH;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rs, rt, dest;
    logic [31:0]       imm;

    id_lane_dec u_dec (
      .instr (IN_INSTR[32*i +: 32]),
      .ctrl  (ctrl),
      .rs    (rs),
      .rt    (rt),
      .dest  (dest),
      .imm   (imm)
    );

    // Empty lanes carry no controls so dispatch never acts on stale words.
    assign dec_lane[i] = '{instr: IN_INSTR[32*i +: 32], pc: IN_PC[32*i +: 32],
                           rs: rs, rt: rt, dest: dest, imm: imm,
                           ctrl: IN_LANE_V[i] ? ctrl : '0};

    assign OUT_INSTR[32*i +: 32]         = buf_data[rd_ptr][i].instr;
    assign OUT_PC[32*i +: 32]            = buf_data[rd_ptr][i].pc;
    assign OUT_RS[5*i +: 5]              = buf_data[rd_ptr][i].rs;
    assign OUT_RT[5*i +: 5]              = buf_data[rd_ptr][i].rt;
    assign OUT_DEST[5*i +: 5]            = buf_data[rd_ptr][i].dest;
    assign OUT_IMM[32*i +: 32]           = buf_data[rd_ptr][i].imm;
    assign OUT_CTRL[CTRL_W*i +: CTRL_W]  = buf_data[rd_ptr][i].ctrl;
  end

  assign OUT_LANE_V = buf_lv[rd_ptr];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (FLUSH) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; count gates its visibility.
  always_ff @(posedge CLK) begin
    if (push) begin
      buf_lv[wr_ptr] <= IN_LANE_V;
      for (int i = 0; i < LANES; i++) buf_data[wr_ptr][i] <= dec_lane[i];
    end
  end

endmodule

// File: tb/tb_id_wide.sv
// Directed self-checking bench for id_wide with two lanes and a two-entry buffer.
module tb_id_wide;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_lane_v, out_lane_v;
  logic [63:0] in_instr, in_pc, out_instr, out_pc, out_imm;
  logic [9:0]  out_rs, out_rt, out_dest;
  logic [21:0] out_ctrl;
  int          checks = 0;
  int          errors = 0;

  id_wide #(.LANES(2), .BUF_DEPTH(2)) dut (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_LANE_V(in_lane_v),
    .IN_INSTR(in_instr), .IN_PC(in_pc),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_LANE_V(out_lane_v),
    .OUT_INSTR(out_instr), .OUT_PC(out_pc), .OUT_RS(out_rs), .OUT_RT(out_rt),
    .OUT_DEST(out_dest), .OUT_IMM(out_imm), .OUT_CTRL(out_ctrl)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] lv,
                               input logic [31:0] i0, input logic [31:0] i1,
                               input logic [31:0] p0, input logic [31:0] p1);
    in_valid  = v;
    in_lane_v = lv;
    in_instr  = {i1, i0};
    in_pc     = {p1, p0};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #3;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    tick;
    rst_n = 1'b1;

    // lw / add bundle, drained straight away
    out_ready = 1'b1;
    applyStimulus(1'b1, 2'b11, 32'h8C410004, 32'h00432020, 32'h100, 32'h104);
    tick;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    checkOutput("a_valid", 32'(out_valid),      32'd1);
    checkOutput("a_ctrl0", 32'(out_ctrl[10:0]),  32'h01E);
    checkOutput("a_ctrl1", 32'(out_ctrl[21:11]), 32'h109);
    checkOutput("a_dest0", 32'(out_dest[4:0]),   32'd1);
    checkOutput("a_dest1", 32'(out_dest[9:5]),   32'd4);
    checkOutput("a_rs0",   32'(out_rs[4:0]),     32'd2);
    checkOutput("a_rt1",   32'(out_rt[9:5]),     32'd3);
    checkOutput("a_imm0",  out_imm[31:0],        32'h4);
    checkOutput("a_pc1",   out_pc[63:32],        32'h104);
    checkOutput("a_instr0", out_instr[31:0],     32'h8C410004);
    tick;
    checkOutput("a_empty", 32'(out_valid), 32'd0);

    // Illegal opcode and immediate forms, streaming back-to-back
    applyStimulus(1'b1, 2'b11, 32'hFC000000, 32'h3421FFFF, 32'h500, 32'h504);
    tick;
    checkOutput("b_ctrl0_illegal", 32'(out_ctrl[10:0]),  32'h400);
    checkOutput("b_ctrl1_ori",     32'(out_ctrl[21:11]), 32'h18A);
    checkOutput("b_imm1_ori",      out_imm[63:32],       32'h0000FFFF);
    applyStimulus(1'b1, 2'b11, 32'h2021FFFF, 32'h3C011234, 32'h508, 32'h50C);
    tick;
    checkOutput("b_pp_valid",    32'(out_valid),      32'd1);
    checkOutput("b_pp_ready",    32'(in_ready),       32'd1);
    checkOutput("b_pp_pc0",      out_pc[31:0],        32'h508);
    checkOutput("b_imm0_addi",   out_imm[31:0],       32'hFFFFFFFF);
    checkOutput("b_imm1_lui",    out_imm[63:32],      32'h12340000);
    checkOutput("b_ctrl1_lui",   32'(out_ctrl[21:11]), 32'h18A);
    applyStimulus(1'b1, 2'b01, 32'h0C000010, 32'hFC000000, 32'h600, 32'h604);
    tick;
    checkOutput("b_ctrl0_jal",  32'(out_ctrl[10:0]),  32'h208);
    checkOutput("b_dest0_jal",  32'(out_dest[4:0]),   32'd31);
    checkOutput("b_ctrl1_off",  32'(out_ctrl[21:11]), 32'h000);
    checkOutput("b_lane_v",     32'(out_lane_v),      32'h1);
    applyStimulus(1'b1, 2'b11, 32'h10220003, 32'hAC410008, 32'h700, 32'h704);
    tick;
    checkOutput("b_ctrl0_beq",  32'(out_ctrl[10:0]),  32'h0C0);
    checkOutput("b_imm0_beq",   out_imm[31:0],        32'h3);
    checkOutput("b_ctrl1_sw",   32'(out_ctrl[21:11]), 32'h022);
    checkOutput("b_dest1_sw",   32'(out_dest[9:5]),   32'd1);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    tick;
    checkOutput("b_empty", 32'(out_valid), 32'd0);

    // Back-pressure: fill, refuse third, push+pop when full, drain in order
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b11, 32'h00432020, 32'h00432020, 32'h200, 32'h204);
    tick;
    checkOutput("c_ready_1", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 2'b11, 32'h00432020, 32'h00432020, 32'h300, 32'h304);
    tick;
    checkOutput("c_ready_full", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 2'b11, 32'h00432020, 32'h00432020, 32'h400, 32'h404);
    tick;
    checkOutput("c_held_ready", 32'(in_ready),  32'd0);
    checkOutput("c_head_x1",    out_pc[31:0],   32'h200);
    out_ready = 1'b1;
    tick;
    checkOutput("c_full_pp_ready", 32'(in_ready), 32'd1);
    checkOutput("c_head_x2",       out_pc[31:0],  32'h300);
    tick;
    checkOutput("c_one_pp_valid", 32'(out_valid), 32'd1);
    checkOutput("c_one_pp_ready", 32'(in_ready),  32'd1);
    checkOutput("c_head_x3",      out_pc[31:0],   32'h400);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    tick;
    checkOutput("c_drained", 32'(out_valid), 32'd0);

    // Flush with a full buffer, then with one entry and a push offered
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b11, 32'h00432020, 32'h00432020, 32'h800, 32'h804);
    tick;
    applyStimulus(1'b1, 2'b11, 32'h00432020, 32'h00432020, 32'h900, 32'h904);
    tick;
    applyStimulus(1'b1, 2'b11, 32'h00432020, 32'h00432020, 32'hA00, 32'hA04);
    flush = 1'b1;
    tick;
    checkOutput("d_full_valid", 32'(out_valid), 32'd0);
    checkOutput("d_full_ready", 32'(in_ready),  32'd1);
    flush = 1'b0;
    applyStimulus(1'b1, 2'b11, 32'h00432020, 32'h00432020, 32'hB00, 32'hB04);
    tick;
    applyStimulus(1'b1, 2'b11, 32'h00432020, 32'h00432020, 32'hC00, 32'hC04);
    flush = 1'b1;
    out_ready = 1'b1;
    tick;
    flush = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    checkOutput("d_one_valid", 32'(out_valid), 32'd0);
    tick;
    checkOutput("d_dropped", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream, then resume
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b11, 32'h00432020, 32'h00432020, 32'hD00, 32'hD04);
    tick;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    checkOutput("e_pre_valid", 32'(out_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("e_async_valid", 32'(out_valid), 32'd0);
    checkOutput("e_async_ready", 32'(in_ready),  32'd1);
    tick;
    #2 rst_n = 1'b1;
    applyStimulus(1'b1, 2'b11, 32'h00432020, 32'h00432020, 32'hE00, 32'hE04);
    tick;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    checkOutput("e_resume_valid", 32'(out_valid), 32'd1);
    checkOutput("e_resume_pc",    out_pc[31:0],   32'hE00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
